motor_driver_model: RTL and testbench

- Cycle-accurate SPI responder that emulates the stepper driver chip's register interface, so motor_driver can be closed-loop tested in simulation and on the bench.
- Accepts 40-bit datagrams from the SPI master and holds the configuration registers.
- Returns status plus pipelined read data. Counts step/dir pulses into a microstep counter.

---
 rtl/motor_driver_model_pkg.sv | 54 +++++
 rtl/motor_driver_model_if.sv | 23 ++
 rtl/motor_driver_model_spi_target_shift.sv | 143 ++++++++++++++
 rtl/motor_driver_model.sv | 138 +++++++++++++
 tb/tb_motor_driver_model.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_driver_model_pkg.sv
// Shared constants for the stepper-driver register model.
// Contents: register addresses and reset values, datagram field positions,
// status bit indices, frame FSM state type and a status-byte helper.
package motor_driver_model_pkg;

    // Register addresses
    localparam logic [6:0] ADDR_GCONF      = 7'h00;
    localparam logic [6:0] ADDR_GSTAT      = 7'h01;
    localparam logic [6:0] ADDR_IHOLD_IRUN = 7'h10;
    localparam logic [6:0] ADDR_TPOWERDOWN = 7'h11;
    localparam logic [6:0] ADDR_TPWMTHRS   = 7'h13;
    localparam logic [6:0] ADDR_MSCNT      = 7'h6A;
    localparam logic [6:0] ADDR_CHOPCONF   = 7'h6C;
    localparam logic [6:0] ADDR_PWMCONF    = 7'h70;

    // Register reset values
    localparam logic [31:0] RST_GCONF      = 32'h0000_0000;
    localparam logic [31:0] RST_IHOLD_IRUN = 32'h0000_0000;
    localparam logic [31:0] RST_TPOWERDOWN = 32'h0000_0000;
    localparam logic [31:0] RST_TPWMTHRS   = 32'h0000_0000;
    localparam logic [31:0] RST_CHOPCONF   = 32'h0000_0000;
    localparam logic [31:0] RST_PWMCONF    = 32'h0005_0480;

    // Datagram layout: {wr, addr[6:0], data[31:0]}
    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned WR_BIT     = 39;
    localparam int unsigned ADDR_MSB   = 38;
    localparam int unsigned ADDR_LSB   = 32;
    localparam int unsigned DATA_MSB   = 31;
    localparam int unsigned DATA_LSB   = 0;

    // Status byte bit indices
    localparam int unsigned STAT_RESET_FLAG = 0;
    localparam int unsigned STAT_TOFF_NZ    = 1;
    localparam int unsigned STAT_STANDSTILL = 2;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SHIFT,
        FR_WAIT_HIGH
    } frame_state_e;

    function automatic logic [7:0] status_byte(input logic standstill,
                                               input logic toff_nz,
                                               input logic reset_flag);
        logic [7:0] s;
        s                  = '0;
        s[STAT_STANDSTILL] = standstill;
        s[STAT_TOFF_NZ]    = toff_nz;
        s[STAT_RESET_FLAG] = reset_flag;
        return s;
    endfunction

endpackage

// File: rtl/motor_driver_model_if.sv
// SPI bus between the driver master and the register-model target.
// Signals: serial_clk_in (SCLK, idle high), cs_n_in (chip select, active low),
// serial_in (MOSI), serial_out (MISO).
interface motor_driver_model_if;
    logic serial_clk_in;
    logic cs_n_in;
    logic serial_in;
    logic serial_out;

    modport master (
        output serial_clk_in,
        output cs_n_in,
        output serial_in,
        input  serial_out
    );

    modport slave (
        input  serial_clk_in,
        input  cs_n_in,
        input  serial_in,
        output serial_out
    );
endinterface

// File: rtl/motor_driver_model_spi_target_shift.sv
// SPI target front end: oversampling synchronizers for SPI and step/dir pins,
// edge detection, frame FSM, 40-bit rx/tx shifters and bit counter.
// Ports:
//   clk_i, rst_i      - system clock, synchronous active-high reset
//   spi               - SPI bus (slave side), drives serial_out
//   step_i, dir_i     - raw step/dir pins
//   tx_data_i         - response word, loaded at frame start
//   frame_start_o     - cycle in which tx_data_i is captured
//   frame_valid_o     - 1-cycle pulse: frame closed with exactly 40 bits
//   frame_err_o       - 1-cycle pulse: frame closed with any other bit count
//   rx_data_o         - received datagram, stable while frame_valid_o is high
//   step_rise_o       - synchronized step rising edge
//   dir_o             - synchronized direction
module motor_driver_model_spi_target_shift
    import motor_driver_model_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    motor_driver_model_if.slave   spi,
    input  logic                  step_i,
    input  logic                  dir_i,
    input  logic [FRAME_BITS-1:0] tx_data_i,
    output logic                  frame_start_o,
    output logic                  frame_valid_o,
    output logic                  frame_err_o,
    output logic [FRAME_BITS-1:0] rx_data_o,
    output logic                  step_rise_o,
    output logic                  dir_o
);

    // Synchronizers are deliberately not reset: they keep tracking the pins
    // during reset so a chip select held low across reset is seen as low,
    // not as a fresh falling edge.
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] pins_s;
    logic       sclk_prev_q, cs_prev_q, step_prev_q;

    always_ff @(posedge clk_i) begin
        sync_q[0] <= {spi.serial_clk_in, spi.cs_n_in, spi.serial_in, step_i, dir_i};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        sclk_prev_q <= pins_s[4];
        cs_prev_q   <= pins_s[3];
        step_prev_q <= pins_s[1];
    end

    assign pins_s = sync_q[SYNC_STAGES-1];

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = pins_s[4];
    assign cs_s      = pins_s[3];
    assign mosi_s    = pins_s[2];
    assign dir_o     = pins_s[0];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_rise   =  cs_s   & ~cs_prev_q;
    assign cs_fall   = ~cs_s   &  cs_prev_q;
    assign step_rise_o = pins_s[1] & ~step_prev_q;

    frame_state_e              state_q, state_d;
    logic [5:0]                bit_cnt_q;
    logic [FRAME_BITS-1:0]     rx_q, tx_q;
    logic                      sout_q, valid_q, err_q;
    logic                      load, sample, shift, valid_d, err_d;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sample  = 1'b0;
        shift   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            FR_IDLE: begin
                // Low chip select without a falling edge means the frame
                // started before reset was released: sit it out.
                if (cs_fall) begin
                    state_d = FR_SHIFT;
                    load    = 1'b1;
                end else if (!cs_s) begin
                    state_d = FR_WAIT_HIGH;
                end
            end
            FR_WAIT_HIGH: begin
                if (cs_s) state_d = FR_IDLE;
            end
            FR_SHIFT: begin
                if (cs_rise) begin
                    state_d = FR_IDLE;
                    if (bit_cnt_q == 6'(FRAME_BITS)) valid_d = 1'b1;
                    else                             err_d   = 1'b1;
                end else begin
                    sample = sclk_rise;
                    // Mode 3: the first falling edge only opens bit 39, which
                    // is already on MISO since frame start; shift from then on.
                    shift  = sclk_fall && (bit_cnt_q != '0);
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FR_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            sout_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (load) begin
                tx_q      <= tx_data_i;
                sout_q    <= tx_data_i[FRAME_BITS-1];
                bit_cnt_q <= '0;
            end
            if (sample) begin
                rx_q <= {rx_q[FRAME_BITS-2:0], mosi_s};
                if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            if (shift) begin
                tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
                sout_q <= tx_q[FRAME_BITS-2];
            end
        end
    end

    assign spi.serial_out = sout_q;
    assign frame_start_o  = load;
    assign frame_valid_o  = valid_q;
    assign frame_err_o    = err_q;
    assign rx_data_o      = rx_q;

endmodule

// File: rtl/motor_driver_model.sv
// Cycle-accurate model of the stepper driver's SPI register interface.
// Holds the configuration registers, returns status plus pipelined read data,
// and counts step/dir pulses into a 10-bit microstep counter.
// Ports:
//   clk_in, reset_in  - only clock; synchronous active-high reset
//   spi               - SPI bus (slave side): SCLK, CS_N, MOSI in, MISO out
//   step_in, dir_in   - step pulse (rising edge counts), direction (1 = up)
//   chopconf_out      - CHOPCONF register
//   ihold_irun_out    - IHOLD_IRUN register
//   mscnt_out         - microstep counter
//   frame_err_out     - 1-cycle pulse on a frame with a bit count other than 40
module motor_driver_model
    import motor_driver_model_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STST_CYCLES = 1048576
) (
    input  logic                clk_in,
    input  logic                reset_in,
    motor_driver_model_if.slave spi,
    input  logic                step_in,
    input  logic                dir_in,
    output logic [31:0]         chopconf_out,
    output logic [31:0]         ihold_irun_out,
    output logic [9:0]          mscnt_out,
    output logic                frame_err_out
);

    localparam int unsigned STST_W = $clog2(STST_CYCLES + 1);

    logic                  frame_start, frame_valid, step_rise, dir_s;
    logic [FRAME_BITS-1:0] rx_data, tx_data;

    motor_driver_model_spi_target_shift #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shift (
        .clk_i        (clk_in),
        .rst_i        (reset_in),
        .spi          (spi),
        .step_i       (step_in),
        .dir_i        (dir_in),
        .tx_data_i    (tx_data),
        .frame_start_o(frame_start),
        .frame_valid_o(frame_valid),
        .frame_err_o  (frame_err_out),
        .rx_data_o    (rx_data),
        .step_rise_o  (step_rise),
        .dir_o        (dir_s)
    );

    logic [31:0]       gconf_q, ihold_q, tpd_q, tpwm_q, chop_q, pwm_q;
    logic [6:0]        read_addr_q;
    logic              reset_flag_q, rd_gstat_q, standstill_q;
    logic [9:0]        mscnt_q;
    logic [STST_W-1:0] stst_cnt_q;
    logic              toff_nz;
    logic [31:0]       read_buf;

    logic              rx_wr;
    logic [6:0]        rx_addr;
    logic [31:0]       rx_dat;

    assign rx_wr   = rx_data[WR_BIT];
    assign rx_addr = rx_data[ADDR_MSB:ADDR_LSB];
    assign rx_dat  = rx_data[DATA_MSB:DATA_LSB];
    assign toff_nz = (chop_q[3:0] != '0);

    always_comb begin
        read_buf = '0;
        case (read_addr_q)
            ADDR_GCONF:      read_buf = gconf_q;
            ADDR_GSTAT:      read_buf = {31'b0, reset_flag_q};
            ADDR_IHOLD_IRUN: read_buf = ihold_q;
            ADDR_TPOWERDOWN: read_buf = tpd_q;
            ADDR_TPWMTHRS:   read_buf = tpwm_q;
            ADDR_MSCNT:      read_buf = {22'b0, mscnt_q};
            ADDR_CHOPCONF:   read_buf = chop_q;
            ADDR_PWMCONF:    read_buf = pwm_q;
            default:         read_buf = '0;
        endcase
    end

    assign tx_data = {status_byte(standstill_q, toff_nz, reset_flag_q), read_buf};

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            gconf_q      <= RST_GCONF;
            ihold_q      <= RST_IHOLD_IRUN;
            tpd_q        <= RST_TPOWERDOWN;
            tpwm_q       <= RST_TPWMTHRS;
            chop_q       <= RST_CHOPCONF;
            pwm_q        <= RST_PWMCONF;
            read_addr_q  <= '0;
            reset_flag_q <= 1'b1;
            rd_gstat_q   <= 1'b0;
        end else begin
            // Remember whether this frame's response carried GSTAT, so the
            // read-to-clear only lands if the frame commits.
            if (frame_start) rd_gstat_q <= (read_addr_q == ADDR_GSTAT);
            if (frame_valid) begin
                if (rx_wr) begin
                    case (rx_addr)
                        ADDR_GCONF:      gconf_q <= rx_dat;
                        ADDR_IHOLD_IRUN: ihold_q <= rx_dat;
                        ADDR_TPOWERDOWN: tpd_q   <= rx_dat;
                        ADDR_TPWMTHRS:   tpwm_q  <= rx_dat;
                        ADDR_CHOPCONF:   chop_q  <= rx_dat;
                        ADDR_PWMCONF:    pwm_q   <= rx_dat;
                        default:         ;
                    endcase
                    if (rx_addr == ADDR_GSTAT && rx_dat[0]) reset_flag_q <= 1'b0;
                end
                if (rd_gstat_q) reset_flag_q <= 1'b0;
                read_addr_q <= rx_addr;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mscnt_q      <= '0;
            stst_cnt_q   <= STST_W'(STST_CYCLES);
            standstill_q <= 1'b1;
        end else if (step_rise) begin
            stst_cnt_q   <= '0;
            standstill_q <= 1'b0;
            if (toff_nz) mscnt_q <= dir_s ? mscnt_q + 10'd1 : mscnt_q - 10'd1;
        end else if (stst_cnt_q != STST_W'(STST_CYCLES)) begin
            stst_cnt_q <= stst_cnt_q + STST_W'(1);
            if (stst_cnt_q == STST_W'(STST_CYCLES - 1)) standstill_q <= 1'b1;
        end
    end

    assign chopconf_out   = chop_q;
    assign ihold_irun_out = ihold_q;
    assign mscnt_out      = mscnt_q;

endmodule

// File: tb/tb_motor_driver_model.sv
// Scoreboard bench for motor_driver_model: directed scenarios followed by
// randomized frames and step bursts, checked against a register-map model.
`timescale 1ns/1ps
module tb_motor_driver_model;

    localparam int unsigned STST = 3000;
    localparam int          H    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] chop, ihold;
    logic [9:0]  mscnt;
    logic        ferr;

    motor_driver_model_if bus();

    motor_driver_model #(
        .SYNC_STAGES(2),
        .STST_CYCLES(STST)
    ) dut (
        .clk_in        (clk),
        .reset_in      (rst),
        .spi           (bus),
        .step_in       (step),
        .dir_in        (dir),
        .chopconf_out  (chop),
        .ihold_irun_out(ihold),
        .mscnt_out     (mscnt),
        .frame_err_out (ferr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int err_pulses = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (ferr === 1'b1) err_pulses++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0] m_regs [int];
    int        m_read_addr;
    bit        m_rf;
    int        m_mscnt;
    bit        m_stepped;
    int        m_last_step;
    int        m_err = 0;

    task automatic model_reset();
        m_regs.delete();
        m_regs['h00] = 0;
        m_regs['h10] = 0;
        m_regs['h11] = 0;
        m_regs['h13] = 0;
        m_regs['h6C] = 0;
        m_regs['h70] = 32'h0005_0480;
        m_read_addr = 0;
        m_rf        = 1;
        m_mscnt     = 0;
        m_stepped   = 0;
    endtask

    function automatic bit [31:0] m_read(input int a);
        if (a == 'h01) return {31'b0, m_rf};
        if (a == 'h6A) return 32'(m_mscnt);
        if (m_regs.exists(a)) return m_regs[a];
        return 0;
    endfunction

    function automatic bit m_toff();
        bit [31:0] c;
        c = m_regs['h6C];
        return c[3:0] != 0;
    endfunction

    function automatic bit [7:0] m_status();
        bit stst;
        stst = !m_stepped || ((cyc - m_last_step) >= int'(STST));
        return {5'b0, stst, m_toff(), m_rf};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         chk;
        logic [39:0] resp;
    } exp_t;
    exp_t sb_q[$];

    initial begin : monitor
        logic [39:0] got;
        exp_t        e;
        forever begin
            @(negedge bus.cs_n_in);
            got = '0;
            forever begin
                @(posedge bus.serial_clk_in or posedge bus.cs_n_in);
                if (bus.cs_n_in) break;
                got = {got[38:0], bus.serial_out};
            end
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) chk("miso_resp", 64'(got), 64'(e.resp));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bits(input logic [39:0] w, input int first, input int nbits);
        for (int i = first; i < first + nbits; i++) begin
            bus.serial_clk_in = 1'b0;
            bus.serial_in     = w[39-i];
            repeat (H) @(negedge clk);
            bus.serial_clk_in = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic do_frame(input logic [39:0] w, input int nbits);
        exp_t e;
        bit   rd_g;
        int   a;
        if (m_stepped) begin
            int el = cyc - m_last_step;
            if (el > int'(STST) - 30 && el < int'(STST) + 30) repeat (60) @(negedge clk);
        end
        e.chk  = (nbits == 40);
        e.resp = {m_status(), m_read(m_read_addr)};
        sb_q.push_back(e);
        rd_g = (m_read_addr == 'h01);
        bus.cs_n_in = 1'b0;
        repeat (8) @(negedge clk);
        send_bits(w, 0, nbits);
        bus.cs_n_in = 1'b1;
        repeat (12) @(negedge clk);
        if (nbits == 40) begin
            a = int'(w[38:32]);
            if (w[39]) begin
                if (m_regs.exists(a)) m_regs[a] = w[31:0];
                if (a == 'h01 && w[0]) m_rf = 0;
            end
            if (rd_g) m_rf = 0;
            m_read_addr = a;
        end else begin
            m_err++;
        end
    endtask

    task automatic do_step(input bit d);
        dir = d;
        repeat (3) @(negedge clk);
        step = 1'b1;
        m_stepped   = 1;
        m_last_step = cyc;
        if (m_toff()) m_mscnt = (m_mscnt + (d ? 1 : 1023)) % 1024;
        repeat (4) @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_chopconf"}, 64'(chop), 64'(m_regs['h6C]));
        chk({tag, "_ihold"}, 64'(ihold), 64'(m_regs['h10]));
        chk({tag, "_mscnt"}, 64'(mscnt), 64'(m_mscnt));
        chk({tag, "_frame_err_cnt"}, 64'(err_pulses), 64'(m_err));
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int addrs [10] = '{'h00, 'h01, 'h10, 'h11, 'h13, 'h6A, 'h6C, 'h70, 'h05, 'h7F};
        exp_t e;
        bus.serial_clk_in = 1'b1;
        bus.cs_n_in       = 1'b1;
        bus.serial_in     = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // reset state
        chk("rst_chopconf", 64'(chop), 64'h0);
        chk("rst_ihold", 64'(ihold), 64'h0);
        chk("rst_mscnt", 64'(mscnt), 64'h0);
        chk("rst_miso", 64'(bus.serial_out), 64'h0);
        chk("rst_frame_err", 64'(ferr), 64'h0);

        // first read after reset: standstill and reset_flag set
        do_frame(40'h00_0000_0000, 40);
        check_outputs("first");

        // CHOPCONF write and readback
        do_frame(40'hEC_0001_00C3, 40);
        chk("chop_after_write", 64'(chop), 64'h0001_00C3);
        do_frame(40'h6C_0000_0000, 40);
        do_frame(40'h00_0000_0000, 40);

        // GSTAT read-to-clear
        do_frame(40'h01_0000_0000, 40);
        do_frame(40'h00_0000_0000, 40);
        do_frame(40'h00_0000_0000, 40);

        // microstep counting with wrap below zero
        do_frame(40'hEC_0000_0003, 40);
        for (int i = 0; i < 5; i++) do_step(1'b1);
        chk("mscnt_up5", 64'(mscnt), 64'(m_mscnt));
        for (int i = 0; i < 7; i++) do_step(1'b0);
        chk("mscnt_wrap", 64'(mscnt), 64'd1022);
        do_frame(40'h6A_0000_0000, 40);
        do_frame(40'h00_0000_0000, 40);

        // short frame: error pulse, no write
        do_frame(40'h90_0006_1F0A, 39);
        chk("short_ihold", 64'(ihold), 64'h0);
        chk("short_err_cnt", 64'(err_pulses), 64'(m_err));
        do_frame(40'h90_0006_1F0A, 40);
        chk("full_ihold", 64'(ihold), 64'h0006_1F0A);

        // reset in the middle of a frame
        e.chk  = 0;
        e.resp = '0;
        sb_q.push_back(e);
        bus.cs_n_in = 1'b0;
        repeat (8) @(negedge clk);
        send_bits(40'hEC_0000_000F, 0, 20);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_bits(40'hEC_0000_000F, 20, 20);
        bus.cs_n_in = 1'b1;
        repeat (12) @(negedge clk);
        check_outputs("abort");
        do_frame(40'hEC_0000_0005, 40);
        do_frame(40'h6C_0000_0000, 40);
        check_outputs("after_abort");

        // randomized traffic
        for (int it = 0; it < 50; it++) begin
            int op = int'($urandom_range(0, 9));
            if (op < 6) begin
                int        a  = addrs[$urandom_range(0, 9)];
                bit        wr = 1'($urandom_range(0, 1));
                bit [31:0] d  = $urandom;
                do_frame({wr, 7'(a), d}, (op == 0 && $urandom_range(0, 3) == 0) ? 38 : 40);
            end else if (op < 9) begin
                bit dr = 1'($urandom_range(0, 1));
                int n  = int'($urandom_range(1, 6));
                for (int k = 0; k < n; k++) do_step(dr);
            end else begin
                repeat (STST + 100) @(negedge clk);
            end
            if (it % 5 == 4) check_outputs("rand");
        end
        do_frame(40'h00_0000_0000, 40);
        check_outputs("final");

        repeat (20) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
